// File: rtl/nor_bus_responder.sv
// NOR flash target model: synchronized async NOR bus, read-latency/page reads, timed programming.
// Optional NOR_RESP_PROG_AND_EN: commits AND old and new data (bits only program 1->0).
module nor_bus_responder #(
    parameter int ADDRBITS    = 26,
    parameter int DATABITS    = 16,
    parameter int MEMBITS     = 8,
    parameter int READ_LAT    = 4,
    parameter int PROG_CYCLES = 20
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                nor_ce_i,
    input  logic                nor_we_i,
    input  logic                nor_oe_i,
    input  logic [ADDRBITS-1:0] nor_addr_i,
    input  logic [DATABITS-1:0] nor_data_i,
    output logic [DATABITS-1:0] nor_data_o,
    output logic                nor_data_oe,
    output logic                nor_ry_o,
    output logic                err_o
);

    localparam int MAXCNT = (READ_LAT > PROG_CYCLES) ? READ_LAT : PROG_CYCLES;
    localparam int CNTW   = $clog2(MAXCNT + 1);
    localparam int DEPTH  = 2 ** MEMBITS;
    localparam logic [CNTW-1:0] READ_LAST = CNTW'(READ_LAT - 1);
    localparam logic [CNTW-1:0] PROG_LAST = CNTW'(PROG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        READ_DRIVE,
        WRITE_LATCH,
        PROG_BUSY
    } state_t;

    state_t              r_state;
    logic [CNTW-1:0]     r_cnt;
    logic                r_ceMeta, r_weMeta, r_oeMeta;
    logic                r_ceSync, r_weSync, r_oeSync;
    logic [ADDRBITS-1:0] r_addrMeta, r_addrSync;
    logic [DATABITS-1:0] r_dataMeta, r_dataSync;
    logic [MEMBITS-1:0]  r_wAddr;
    logic [DATABITS-1:0] r_wData;
    logic [DATABITS-1:0] r_dataOut;
    logic                r_dataOe;
    logic                r_ry;
    logic                r_err;
    logic [DATABITS-1:0] r_mem [DEPTH];

    logic [MEMBITS-1:0]  w_addr;
    logic [DATABITS-1:0] w_commitData;

    assign w_addr = r_addrSync[MEMBITS-1:0];

`ifdef NOR_RESP_PROG_AND_EN
    assign w_commitData = r_mem[r_wAddr] & r_wData;
`else
    assign w_commitData = r_wData;
`endif

    // Two-flop synchronizers; controls idle high so reset looks like a deselected bus
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ceMeta   <= 1'b1;
            r_weMeta   <= 1'b1;
            r_oeMeta   <= 1'b1;
            r_ceSync   <= 1'b1;
            r_weSync   <= 1'b1;
            r_oeSync   <= 1'b1;
            r_addrMeta <= '0;
            r_addrSync <= '0;
            r_dataMeta <= '0;
            r_dataSync <= '0;
        end else begin
            r_ceMeta   <= nor_ce_i;
            r_weMeta   <= nor_we_i;
            r_oeMeta   <= nor_oe_i;
            r_ceSync   <= r_ceMeta;
            r_weSync   <= r_weMeta;
            r_oeSync   <= r_oeMeta;
            r_addrMeta <= nor_addr_i;
            r_addrSync <= r_addrMeta;
            r_dataMeta <= nor_data_i;
            r_dataSync <= r_dataMeta;
        end
    end

    // The array resets to erased state, so an interrupted program can never leave a partial word
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wAddr   <= '0;
            r_wData   <= '0;
            r_dataOut <= '0;
            r_dataOe  <= 1'b0;
            r_ry      <= 1'b1;
            r_err     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '1;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (!r_ceSync && !r_weSync) begin
                        r_state <= WRITE_LATCH;
                        r_wAddr <= w_addr;
                        r_wData <= r_dataSync;
                    end else if (!r_ceSync && !r_oeSync) begin
                        r_state <= READ_WAIT;
                        r_cnt   <= '0;
                    end
                end
                READ_WAIT: begin
                    if (r_ceSync || r_oeSync) begin
                        r_state <= IDLE;
                    end else if (r_cnt >= READ_LAST) begin
                        r_state   <= READ_DRIVE;
                        r_dataOe  <= 1'b1;
                        r_dataOut <= r_mem[w_addr];
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                READ_DRIVE: begin
                    if (r_ceSync || r_oeSync) begin
                        r_state  <= IDLE;
                        r_dataOe <= 1'b0;
                    end else begin
                        r_dataOut <= r_mem[w_addr];
                    end
                end
                WRITE_LATCH: begin
                    if (!r_ceSync && !r_weSync) begin
                        r_wAddr <= w_addr;
                        r_wData <= r_dataSync;
                    end else begin
                        r_mem[r_wAddr] <= w_commitData;
                        r_state        <= PROG_BUSY;
                        r_cnt          <= '0;
                        r_ry           <= 1'b0;
                    end
                end
                PROG_BUSY: begin
                    // A write while busy is flagged and dropped; the busy timer keeps running
                    if (!r_ceSync && !r_weSync) begin
                        r_err <= 1'b1;
                    end
                    if (r_cnt >= PROG_LAST) begin
                        r_state <= IDLE;
                        r_ry    <= 1'b1;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign nor_data_o  = r_dataOut;
    assign nor_data_oe = r_dataOe;
    assign nor_ry_o    = r_ry;
    assign err_o       = r_err;

endmodule

// File: tb/tb_nor_bus_responder.sv
// Directed self-checking bench for nor_bus_responder; inputs driven and outputs sampled on the falling edge.
// Honours NOR_RESP_PROG_AND_EN when choosing the expected result of a double program.
module tb_nor_bus_responder;

    logic        clk_i;
    logic        rst_ni;
    logic        nor_ce_i, nor_we_i, nor_oe_i;
    logic [25:0] nor_addr_i;
    logic [15:0] nor_data_i;
    logic [15:0] nor_data_o;
    logic        nor_data_oe;
    logic        nor_ry_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    nor_bus_responder dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .nor_ce_i   (nor_ce_i),
        .nor_we_i   (nor_we_i),
        .nor_oe_i   (nor_oe_i),
        .nor_addr_i (nor_addr_i),
        .nor_data_i (nor_data_i),
        .nor_data_o (nor_data_o),
        .nor_data_oe(nor_data_oe),
        .nor_ry_o   (nor_ry_o),
        .err_o      (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One complete program: hold CE/WE low a few cycles, release, then time the busy window
    task automatic applyStimulus(input logic [25:0] addr, input logic [15:0] data, input bit withOe,
                                 output int busy);
        bit sawOe;
        sawOe = 1'b0;
        @(negedge clk_i);
        nor_ce_i   = 1'b0;
        nor_we_i   = 1'b0;
        nor_oe_i   = withOe ? 1'b0 : 1'b1;
        nor_addr_i = addr;
        nor_data_i = data;
        repeat (3) begin
            @(negedge clk_i);
            sawOe |= nor_data_oe;
        end
        nor_ce_i = 1'b1;
        nor_we_i = 1'b1;
        nor_oe_i = 1'b1;
        for (int i = 0; i < 20 && nor_ry_o; i++) begin
            @(negedge clk_i);
            sawOe |= nor_data_oe;
        end
        busy = 0;
        while (!nor_ry_o && busy < 100) begin
            busy++;
            @(negedge clk_i);
            sawOe |= nor_data_oe;
        end
        checkOutput("write_no_drive", 32'(sawOe), 32'h0);
        repeat (2) @(negedge clk_i);
    endtask

    task automatic readWord(input logic [25:0] addr, output logic [15:0] data, output int lat, output int fall);
        @(negedge clk_i);
        nor_ce_i   = 1'b0;
        nor_oe_i   = 1'b0;
        nor_addr_i = addr;
        lat = 0;
        while (!nor_data_oe && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
        data     = nor_data_o;
        nor_ce_i = 1'b1;
        nor_oe_i = 1'b1;
        fall = 0;
        while (nor_data_oe && fall < 40) begin
            @(negedge clk_i);
            fall++;
        end
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        logic [15:0] rd;
        int          lat, fall, busy, cnt;
        bit          drop;
        logic [15:0] pageVals [4];
        pageVals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

        rst_ni     = 1'b0;
        nor_ce_i   = 1'b1;
        nor_we_i   = 1'b1;
        nor_oe_i   = 1'b1;
        nor_addr_i = '0;
        nor_data_i = '0;

        repeat (3) @(negedge clk_i);
        checkOutput("rst_ry", 32'(nor_ry_o), 32'h1);
        checkOutput("rst_oe", 32'(nor_data_oe), 32'h0);
        checkOutput("rst_data", 32'(nor_data_o), 32'h0);
        checkOutput("rst_err", 32'(err_o), 32'h0);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);

        $display("[TB] erased read of 0x05");
        readWord(26'h05, rd, lat, fall);
        checkOutput("erased_lat", 32'(lat), 32'd7);
        checkOutput("erased_data", 32'(rd), 32'hFFFF);
        checkOutput("erased_oe_fall", 32'(fall), 32'd3);
        checkOutput("erased_ry", 32'(nor_ry_o), 32'h1);
        checkOutput("erased_err", 32'(err_o), 32'h0);

        $display("[TB] program 0x1234 to 0x05");
        applyStimulus(26'h05, 16'h1234, 1'b0, busy);
        checkOutput("prog_busy_len", 32'(busy), 32'd20);
        readWord(26'h05, rd, lat, fall);
        checkOutput("prog_readback", 32'(rd), 32'h1234);

        $display("[TB] double program of 0x10");
        applyStimulus(26'h10, 16'h00FF, 1'b0, busy);
        applyStimulus(26'h10, 16'h0F0F, 1'b0, busy);
        readWord(26'h10, rd, lat, fall);
`ifdef NOR_RESP_PROG_AND_EN
        checkOutput("double_prog", 32'(rd), 32'h000F);
`else
        checkOutput("double_prog", 32'(rd), 32'h0F0F);
`endif

        $display("[TB] WE wins over OE");
        applyStimulus(26'h50, 16'h0A0A, 1'b1, busy);
        checkOutput("we_prio_busy", 32'(busy), 32'd20);
        readWord(26'h50, rd, lat, fall);
        checkOutput("we_prio_data", 32'(rd), 32'h0A0A);

        $display("[TB] write attempt while busy");
        @(negedge clk_i);
        nor_ce_i   = 1'b0;
        nor_we_i   = 1'b0;
        nor_addr_i = 26'h30;
        nor_data_i = 16'hABCD;
        repeat (3) @(negedge clk_i);
        nor_ce_i = 1'b1;
        nor_we_i = 1'b1;
        for (int i = 0; i < 20 && nor_ry_o; i++) @(negedge clk_i);
        checkOutput("busy_err_before", 32'(err_o), 32'h0);
        busy = 0;
        while (!nor_ry_o && busy < 100) begin
            busy++;
            if (busy == 4) begin
                nor_ce_i   = 1'b0;
                nor_we_i   = 1'b0;
                nor_data_i = 16'hDEAD;
            end
            if (busy == 7) begin
                nor_ce_i = 1'b1;
                nor_we_i = 1'b1;
            end
            @(negedge clk_i);
        end
        checkOutput("busy_len_kept", 32'(busy), 32'd20);
        checkOutput("busy_err_set", 32'(err_o), 32'h1);
        repeat (2) @(negedge clk_i);
        readWord(26'h30, rd, lat, fall);
        checkOutput("busy_drop_data", 32'(rd), 32'hABCD);
        checkOutput("busy_err_sticky", 32'(err_o), 32'h1);

        $display("[TB] page read 0x20..0x23");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(26'h20 + 26'(i), pageVals[i], 1'b0, busy);
        end
        @(negedge clk_i);
        nor_ce_i   = 1'b0;
        nor_oe_i   = 1'b0;
        nor_addr_i = 26'h20;
        lat = 0;
        while (!nor_data_oe && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
        checkOutput("page_lat", 32'(lat), 32'd7);
        checkOutput("page_word0", 32'(nor_data_o), 32'h1111);
        for (int i = 1; i < 4; i++) begin
            nor_addr_i = 26'h20 + 26'(i);
            drop = 1'b0;
            repeat (3) begin
                @(negedge clk_i);
                if (!nor_data_oe) drop = 1'b1;
            end
            checkOutput($sformatf("page_word%0d", i), 32'(nor_data_o), 32'(pageVals[i]));
            checkOutput($sformatf("page_hold%0d", i), 32'(drop), 32'h0);
        end
        nor_ce_i = 1'b1;
        nor_oe_i = 1'b1;
        cnt = 0;
        while (nor_data_oe && cnt < 40) begin
            @(negedge clk_i);
            cnt++;
        end
        repeat (2) @(negedge clk_i);
        readWord(26'h120, rd, lat, fall);
        checkOutput("alias_data", 32'(rd), 32'h1111);

        $display("[TB] reset during program");
        @(negedge clk_i);
        nor_ce_i   = 1'b0;
        nor_we_i   = 1'b0;
        nor_addr_i = 26'h40;
        nor_data_i = 16'h5555;
        repeat (3) @(negedge clk_i);
        nor_ce_i = 1'b1;
        nor_we_i = 1'b1;
        for (int i = 0; i < 20 && nor_ry_o; i++) @(negedge clk_i);
        checkOutput("midrst_busy", 32'(nor_ry_o), 32'h0);
        repeat (6) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        checkOutput("midrst_ry", 32'(nor_ry_o), 32'h1);
        checkOutput("midrst_oe", 32'(nor_data_oe), 32'h0);
        checkOutput("midrst_err", 32'(err_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        readWord(26'h40, rd, lat, fall);
        checkOutput("postrst_lat", 32'(lat), 32'd7);
        checkOutput("postrst_0x40", 32'(rd), 32'hFFFF);
        readWord(26'h05, rd, lat, fall);
        checkOutput("postrst_0x05", 32'(rd), 32'hFFFF);
        readWord(26'h20, rd, lat, fall);
        checkOutput("postrst_0x20", 32'(rd), 32'hFFFF);
        checkOutput("postrst_ry", 32'(nor_ry_o), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nor_bus_responder.md
NOR_BUS_RESPONDER -- requirements
Module: nor_bus_responder

Interface
REQ-001 Parameters SHALL be: ADDRBITS, default 26, NOR address width; DATABITS, default 16, data width; MEMBITS, default 8, implemented word-address bits; READ_LAT, default 4, access cycles before data drive; PROG_CYCLES, default 20, busy cycles per program.
REQ-002 clk_i  in  1  single clock; all state SHALL be on its rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 nor_ce_i, nor_we_i, nor_oe_i  in  1 each  active-low chip enable, write enable and output enable from the NOR initiator.
REQ-005 nor_addr_i  in  ADDRBITS  word address; only bits [MEMBITS-1:0] SHALL be decoded, upper bits ignored (aliasing).
REQ-006 nor_data_i  in  DATABITS  write data from the initiator.
REQ-007 nor_data_o  out  DATABITS  read data toward the initiator.
REQ-008 nor_data_oe  out  1  1 = drive nor_data_o, 0 = high-Z.
REQ-009 nor_ry_o  out  1  ready/busy; 0 = programming in progress.
REQ-010 err_o  out  1  sticky error flag.

Function
REQ-011 All NOR inputs SHALL pass through 2-flop synchronizers; all decisions SHALL use the synchronized values (s_ce, s_we, s_oe, s_addr, s_data).
REQ-012 Storage SHALL be 2**MEMBITS words of DATABITS bits.
REQ-013 FSM states SHALL be IDLE, READ_WAIT, READ_DRIVE, WRITE_LATCH, PROG_BUSY.
REQ-014 IDLE: s_ce=0 and s_we=0 -> WRITE_LATCH; otherwise s_ce=0 and s_oe=0 -> READ_WAIT, with the access counter cleared. WE SHALL take priority when WE and OE are both low.
REQ-015 READ_WAIT: after READ_LAT cycles -> READ_DRIVE; s_ce or s_oe high first -> IDLE with no drive.
REQ-016 READ_DRIVE: nor_data_oe=1; nor_data_o SHALL be registered mem[s_addr] and re-evaluated every cycle (page reads without re-wait).
REQ-017 READ_DRIVE: s_ce or s_oe high -> IDLE; nor_data_oe SHALL fall on the following edge.
REQ-018 WRITE_LATCH: s_addr and s_data SHALL be captured every cycle while s_we=0 and s_ce=0. On s_we or s_ce returning high, the last captured pair SHALL be committed and the FSM SHALL enter PROG_BUSY.
REQ-019 PROG_BUSY: nor_ry_o=0 for exactly PROG_CYCLES cycles, then -> IDLE with nor_ry_o=1. The memory write SHALL occur on the PROG_BUSY entry edge.
REQ-020 PROG_BUSY reads: ignored, nor_data_oe=0.
REQ-021 PROG_BUSY writes: any s_ce=0 and s_we=0 cycle SHALL set err_o; the data SHALL be dropped and the busy count SHALL be unaffected.
REQ-022 After PROG_BUSY, if CE/WE/OE are still asserted, IDLE SHALL re-evaluate them on the next cycle per REQ-014.
REQ-023 The counter SHALL be wide enough for max(READ_LAT, PROG_CYCLES) and SHALL saturate, never wrap.

Reset
REQ-024 While rst_ni=0, regardless of current state (including mid-program), the block SHALL hold: state=IDLE, nor_data_oe=0, nor_data_o=0, nor_ry_o=1, err_o=0, counter=0, synchronizers at control=1 / addr=0 / data=0.
REQ-025 Storage SHALL reset to all-ones (erased NOR). An interrupted program SHALL leave the array as written at PROG_BUSY entry or reset value, never partial.

Configuration
REQ-026 Macro NOR_RESP_PROG_AND_EN: defined -> commit SHALL store old AND new (bits only 1->0, NOR program semantics); undefined -> commit SHALL overwrite with new data.

Verification
REQ-027 Reset, then read addr 0x05 -> nor_data_oe=1 after READ_LAT plus synchronizer delay; nor_data_o=0xFFFF; nor_ry_o=1; err_o=0.
REQ-028 Write 0x1234 to 0x05 -> nor_ry_o=0 for 20 cycles then 1; a read of 0x05 returns 0x1234.
REQ-029 With NOR_RESP_PROG_AND_EN, write 0x00FF then 0x0F0F to 0x10 -> read returns 0x000F; without the macro the read returns 0x0F0F.
REQ-030 Write attempt during PROG_BUSY -> err_o=1 and stays 1; the target word is unchanged; busy still lasts 20 cycles from the first commit.
REQ-031 CE/OE held low while the address steps 0x20..0x23 -> four consecutive words driven with no READ_WAIT re-entry; address 0x120 aliases 0x20.
REQ-032 rst_ni low at busy cycle 7 -> nor_ry_o=1 immediately; after release the FSM is in IDLE and the array is all-ones.
